iq_stream_serializer: RTL

- Transmit-side counterpart of the channel deserializer (grab_channels) that sits after the down-converter.
- Latches one parallel snapshot of N_CH complex (I/Q) channel results on a strobe, then emits it as a time-multiplexed word stream with a per-word strobe.
- Word order: I0,Q0,I1,Q1,… — the format the deserializer consumes.
- Sits between the per-channel CIC/CORDIC outputs and the stream consumers in the vvm_dsp datapath.
- Provides one-deep frame buffering and sticky overrun detection.

---
 rtl/iq_stream_serializer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/iq_stream_serializer.sv
// iq_stream_serializer: snapshot of N_CH I/Q pairs -> word stream I0,Q0,I1,Q1,...
// Optional trailing XOR checksum word: define IQ_STREAM_CHECKSUM_EN.
module iq_stream_serializer #(
  parameter int DW   = 21,
  parameter int N_CH = 4
) (
  input  logic               sample_clk,
  input  logic               sample_rst_n,
  input  logic               strobe_in,
  input  logic [N_CH*DW-1:0] i_in,
  input  logic [N_CH*DW-1:0] q_in,
  input  logic               clear_ovf,
  output logic [DW-1:0]      stream_out,
  output logic               strobe_out,
  output logic               first_out,
  output logic               last_out,
  output logic               busy,
  output logic               overrun
);

  localparam int NW = 2 * N_CH;
`ifdef IQ_STREAM_CHECKSUM_EN
  localparam int LEN = NW + 1;
`else
  localparam int LEN = NW;
`endif
  localparam int CW = $clog2(NW + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic {IDLE, SEND} state_e;
  typedef logic [NW-1:0][DW-1:0] frame_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  frame_t        act_q, act_d;
  frame_t        pend_q, pend_d;
  logic          pvld_q, pvld_d;
  logic [DW-1:0] data_q, data_d;
  logic          stb_q, stb_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          ovf_q, ovf_d;

  frame_t        frm_in;
  logic [CW-1:0] nxt;
  logic [DW-1:0] nxt_word;

  // Interleave the packed channel buses into transmit order.
  always_comb begin
    frm_in = '0;
    for (int k = 0; k < N_CH; k++) begin
      frm_in[2*k]   = i_in[k*DW +: DW];
      frm_in[2*k+1] = q_in[k*DW +: DW];
    end
  end

`ifdef IQ_STREAM_CHECKSUM_EN
  logic [DW-1:0] chk;

  // XOR of all data words of the frame in flight.
  always_comb begin
    chk = '0;
    for (int k = 0; k < NW; k++) begin
      chk = chk ^ act_q[k];
    end
  end
`endif

  assign nxt = cnt_q + CW'(1);

  // Select the word that follows the one now on the output.
  always_comb begin
    nxt_word = '0;
    for (int k = 0; k < NW; k++) begin
      if (nxt == CW'(k)) nxt_word = act_q[k];
    end
`ifdef IQ_STREAM_CHECKSUM_EN
    if (nxt == CW'(NW)) nxt_word = chk;
`endif
  end

  // Next-state: frame start, word stepping, pending slot and overrun.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    data_d  = data_q;
    stb_d   = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    ovf_d   = clear_ovf ? 1'b0 : ovf_q;

    unique case (state_q)
      IDLE: begin
        if (strobe_in) begin
          act_d   = frm_in;
          cnt_d   = '0;
          state_d = SEND;
          data_d  = frm_in[0];
          stb_d   = 1'b1;
          first_d = 1'b1;
        end
      end
      SEND: begin
        if (cnt_q == LAST) begin
          if (pvld_q) begin
            act_d   = pend_q;
            cnt_d   = '0;
            data_d  = pend_q[0];
            stb_d   = 1'b1;
            first_d = 1'b1;
            if (strobe_in) pend_d = frm_in;
            else           pvld_d = 1'b0;
          end else if (strobe_in) begin
            act_d   = frm_in;
            cnt_d   = '0;
            data_d  = frm_in[0];
            stb_d   = 1'b1;
            first_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d  = nxt;
          data_d = nxt_word;
          stb_d  = 1'b1;
          last_d = (nxt == LAST);
          if (strobe_in) begin
            if (!pvld_q) begin
              pend_d = frm_in;
              pvld_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      data_q  <= '0;
      stb_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      data_q  <= data_d;
      stb_q   <= stb_d;
      first_q <= first_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign stream_out = data_q;
  assign strobe_out = stb_q;
  assign first_out  = first_q;
  assign last_out   = last_q;
  assign busy       = (state_q == SEND) | pvld_q;
  assign overrun    = ovf_q;

endmodule
